// File: rtl/ws2812_pkg.sv
// Shared command encoding and sequencer state type for the WS2812 transmit path.
// The encoder imports the same command constants so both sides agree on the symbol codes.
package ws2812_pkg;

  localparam int PIXEL_W = 24;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_TX    = 2'b01;
  localparam logic [1:0] CMD_RESET = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TX,
    ST_STALL,
    ST_LATCH
  } seq_state_t;

endpackage

// File: rtl/ws2812_pixel_hold.sv
// One-entry valid/ready buffer holding the next pixel word and its end-of-frame flag.
// The ready output stays low until the first clock after reset release.
module ws2812_pixel_hold
  import ws2812_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PIXEL_W-1:0] in_data,
  input  logic               in_last,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               take,
  output logic [PIXEL_W-1:0] hold_data,
  output logic               hold_last,
  output logic               hold_valid
);

  logic armed;

  assign in_ready = armed && !hold_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed      <= 1'b0;
      hold_valid <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (in_valid && in_ready) begin
        hold_valid <= 1'b1;
      end else if (take) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Payload is only meaningful while hold_valid is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      hold_data <= in_data;
      hold_last <= in_last;
    end
  end

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Feeds GRB pixel words MSB-first into the unipolar RZ encoder, one bit per CMD_TX symbol,
// and closes each frame with a run of RESET_BITS CMD_RESET symbols.
module ws2812_frame_sequencer
  import ws2812_pkg::*;
#(
  parameter int RESET_BITS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] pix_data,
  input  logic        pix_last,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        enc_cmd_req,
  input  logic        enc_data_req,
  output logic [1:0]  enc_cmd,
  output logic        enc_databit,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun,
  input  logic        underrun_clr
);

  localparam logic [9:0] LATCH_INIT = 10'(RESET_BITS - 1);
  localparam logic [4:0] TOP_BIT    = 5'(PIXEL_W - 1);

  seq_state_t         state;
  logic [PIXEL_W-1:0] shreg;
  logic               shreg_last;
  logic [4:0]         bit_cnt;
  logic [9:0]         latch_cnt;
  logic [PIXEL_W-1:0] hold_data;
  logic               hold_last;
  logic               hold_valid;
  logic               take;
  logic               boundary;

  assign boundary    = (state == ST_TX) && enc_data_req && (bit_cnt == 5'd0);
  assign enc_databit = (state == ST_TX) && shreg[PIXEL_W-1];

  // The hold buffer empties into shreg on the same edge the state machine consumes it.
  always_comb begin
    take = 1'b0;
    case (state)
      ST_IDLE, ST_STALL: take = hold_valid;
      ST_TX:             take = boundary && !shreg_last && hold_valid;
      default:           take = 1'b0;
    endcase
  end

  ws2812_pixel_hold u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (pix_data),
    .in_last    (pix_last),
    .in_valid   (pix_valid),
    .in_ready   (pix_ready),
    .take       (take),
    .hold_data  (hold_data),
    .hold_last  (hold_last),
    .hold_valid (hold_valid)
  );

  always_ff @(posedge clk) begin
    if (take) begin
      shreg      <= hold_data;
      shreg_last <= hold_last;
    end else if ((state == ST_TX) && enc_data_req) begin
      shreg <= {shreg[PIXEL_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= 5'd0;
      latch_cnt  <= 10'd0;
      enc_cmd    <= CMD_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (underrun_clr) begin
        underrun <= 1'b0;
      end
      case (state)
        ST_IDLE, ST_STALL: begin
          if (hold_valid) begin
            state   <= ST_TX;
            bit_cnt <= TOP_BIT;
            enc_cmd <= CMD_TX;
            busy    <= 1'b1;
          end
        end
        ST_TX: begin
          if (enc_data_req) begin
            bit_cnt <= bit_cnt - 5'd1;
            if (bit_cnt == 5'd0) begin
              if (shreg_last) begin
                state     <= ST_LATCH;
                latch_cnt <= LATCH_INIT;
                enc_cmd   <= CMD_RESET;
              end else if (hold_valid) begin
                bit_cnt <= TOP_BIT;
              end else begin
                // Set placed after the clear so it wins in the same cycle.
                state    <= ST_STALL;
                enc_cmd  <= CMD_IDLE;
                underrun <= 1'b1;
              end
            end
          end
        end
        ST_LATCH: begin
          if (enc_cmd_req) begin
            latch_cnt <= latch_cnt - 10'd1;
            if (latch_cnt == 10'd0) begin
              state      <= ST_IDLE;
              enc_cmd    <= CMD_IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
